bsg_comm_link_token_credit_tx: RTL and testbench

- Transmit-side credit tracker for one link channel.
- It is the sending end of the token flow control whose receiving end decimates freed input-FIFO slots into the token clock.
- It sits between the core-side channel data and the source-synchronous output serializer.
- It gates the data handshake so the far-end input FIFO never overflows, and converts token-clock transitions back into credits.

---
 rtl/bsg_comm_link_token_credit_tx.sv | 62 ++++++
 tb/tb_bsg_comm_link_token_credit_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_comm_link_token_credit_tx.sv
// Transmit-side credit tracker: gates the core->serializer handshake on far-end
// FIFO credits and turns token-clock transitions back into credits.
module bsg_comm_link_token_credit_tx #(
    parameter int width_p                         = 16,
    parameter int lg_input_fifo_depth_p           = 5,
    parameter int lg_credit_to_token_decimation_p = 3
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             token_toggle_i,
    input  logic                             v_i,
    input  logic [width_p-1:0]               data_i,
    output logic                             ready_o,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    input  logic                             ready_i,
    output logic [lg_input_fifo_depth_p:0]   credit_count_o,
    output logic                             credit_error_o
);

    localparam int CW = lg_input_fifo_depth_p + 1;
    localparam int NW = lg_input_fifo_depth_p + 2;
    localparam logic [NW-1:0] FULL_N = NW'(2 ** lg_input_fifo_depth_p);
    localparam logic [NW-1:0] DEC_N  = NW'(2 ** lg_credit_to_token_decimation_p);

    logic [CW-1:0] r_credits;
    logic          r_token;
    logic          r_error;

    logic          w_has_credit;
    logic          w_send;
    logic          w_token_edge;
    logic [NW-1:0] w_next;

    assign w_has_credit = (r_credits != '0);
    assign w_send       = v_i & ready_i & w_has_credit;
    assign w_token_edge = token_toggle_i ^ r_token;

    // One extra bit of headroom so a token return past full is seen, not wrapped.
    assign w_next = {1'b0, r_credits} - NW'(w_send) + (w_token_edge ? DEC_N : '0);

    assign v_o            = v_i & w_has_credit;
    assign ready_o        = ready_i & w_has_credit;
    assign data_o         = data_i;
    assign credit_count_o = r_credits;
    assign credit_error_o = r_error;

    always_ff @(posedge clk_i) begin
        // Token level is tracked through reset so a level held across release is not an edge.
        r_token <= token_toggle_i;
        if (reset_i) begin
            r_credits <= FULL_N[CW-1:0];
            r_error   <= 1'b0;
        end else if (w_next > FULL_N) begin
            r_credits <= FULL_N[CW-1:0];
            r_error   <= 1'b1;
        end else begin
            r_credits <= w_next[CW-1:0];
        end
    end

endmodule

// File: tb/tb_bsg_comm_link_token_credit_tx.sv
// Self-checking bench: directed credit scenarios plus randomized traffic
// against a credit-counting reference model.
module tb_bsg_comm_link_token_credit_tx;

    localparam int W    = 16;
    localparam int LG   = 5;
    localparam int DEC  = 3;
    localparam int FULL = 32;
    localparam int TOK  = 8;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          token_toggle_i = 1'b1;
    logic          v_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          ready_i = 1'b0;
    logic          ready_o, v_o, credit_error_o;
    logic [W-1:0]  data_o;
    logic [LG:0]   credit_count_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // reference model state
    int m_credits = FULL;
    int m_err     = 0;
    bit m_tok     = 1'b1;

    always #5 clk = ~clk;

    bsg_comm_link_token_credit_tx #(
        .width_p(W),
        .lg_input_fifo_depth_p(LG),
        .lg_credit_to_token_decimation_p(DEC)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .token_toggle_i(token_toggle_i),
        .v_i(v_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .v_o(v_o),
        .data_o(data_o),
        .ready_i(ready_i),
        .credit_count_o(credit_count_o),
        .credit_error_o(credit_error_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: credits drop by one per accepted word, rise by a token's worth per
    // token-level change, capped at full with a sticky overflow flag.
    always @(posedge clk) begin
        if (reset_i) begin
            m_credits = FULL;
            m_err     = 0;
        end else begin
            if (v_i && ready_i && m_credits > 0) m_credits = m_credits - 1;
            if (token_toggle_i != m_tok) m_credits = m_credits + TOK;
            if (m_credits > FULL) begin
                m_credits = FULL;
                m_err     = 1;
            end
            if (m_credits < 0) begin
                errors++;
                $display("FAIL model_underflow: got %0d expected >=0", m_credits);
            end
        end
        m_tok = token_toggle_i;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("credit_count", int'(credit_count_o), m_credits);
            chk("credit_error", int'(credit_error_o), m_err);
            chk("v_o", int'(v_o), int'(v_i && m_credits > 0));
            chk("ready_o", int'(ready_o), int'(ready_i && m_credits > 0));
            chk("data_o", int'(data_o), int'(data_i));
            chk("credit_range", int'(credit_count_o <= FULL), 1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    bit last_toggled;

    initial begin
        // reset with token already high
        repeat (3) cyc();
        chk_en  = 1'b1;
        reset_i = 1'b0;
        ready_i = 1'b1;
        cyc();
        chk("rst_credits", int'(credit_count_o), 32);
        chk("rst_error", int'(credit_error_o), 0);
        chk("rst_ready", int'(ready_o), 1);
        cyc();
        chk("no_spurious_edge", int'(credit_count_o), 32);

        // drain all credits
        v_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            data_i = W'($urandom);
            cyc();
            chk("drain", int'(credit_count_o), 31 - i);
        end
        chk("empty_v_o", int'(v_o), 0);
        chk("empty_ready_o", int'(ready_o), 0);

        // one token at empty
        token_toggle_i = 1'b0;
        cyc();
        chk("token_at_empty", int'(credit_count_o), 8);
        chk("resume_v_o", int'(v_o), 1);
        repeat (8) cyc();
        chk("redrain", int'(credit_count_o), 0);

        // reach 5, then send and token together
        v_i = 1'b0;
        token_toggle_i = 1'b1;
        cyc();
        chk("refill8", int'(credit_count_o), 8);
        v_i = 1'b1;
        repeat (3) cyc();
        chk("at5", int'(credit_count_o), 5);
        token_toggle_i = 1'b0;
        cyc();
        chk("send_and_token", int'(credit_count_o), 12);

        // overflow from 30
        reset_i = 1'b1;
        v_i = 1'b0;
        cyc();
        reset_i = 1'b0;
        v_i = 1'b1;
        repeat (2) cyc();
        chk("at30", int'(credit_count_o), 30);
        v_i = 1'b0;
        token_toggle_i = 1'b1;
        cyc();
        chk("overflow_sat", int'(credit_count_o), 32);
        chk("overflow_flag", int'(credit_error_o), 1);
        v_i = 1'b1;
        repeat (5) cyc();
        chk("after_traffic", int'(credit_count_o), 27);
        chk("flag_sticky", int'(credit_error_o), 1);

        // reset mid-burst at 7 with token toggling
        repeat (20) cyc();
        chk("at7", int'(credit_count_o), 7);
        reset_i = 1'b1;
        token_toggle_i = 1'b0;
        cyc();
        chk("midreset_credits", int'(credit_count_o), 32);
        chk("midreset_flag", int'(credit_error_o), 0);
        token_toggle_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        v_i = 1'b0;
        cyc();
        chk("post_release", int'(credit_count_o), 32);
        cyc();
        chk("post_release2", int'(credit_count_o), 32);

        // randomized traffic, token level changes no faster than every other cycle
        last_toggled = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            v_i     = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            data_i  = W'($urandom);
            reset_i = ($urandom_range(0, 299) == 0);
            if (!last_toggled && $urandom_range(0, 5) == 0) begin
                token_toggle_i = ~token_toggle_i;
                last_toggled   = 1'b1;
            end else begin
                last_toggled   = 1'b0;
            end
            cyc();
        end

        reset_i = 1'b0;
        cyc();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
